// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fsm
// Description : Multi-cycle processor control FSM. It sequences instruction
//               fetch, decode, execute and data-memory access. It bounds
//               every memory wait with a timeout, and it counts retired
//               instructions.
// Ports       : clock, reset      - clock; asynchronous active-high reset
//               inst_type[3:0]    - decoded instruction class held in the IR
//               mem_ready         - memory completes the current request
//               mem_req/mem_we/mem_size/addr_sel - memory request controls
//               ir_we, reg_we, wb_sel, pc_we, pc_sel - datapath strobes
//               halt, error, err_cause - status
//               state, instret     - debug observability
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  inst_type,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        halt,
    output logic        error,
    output logic [1:0]  err_cause,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    localparam int C_WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_HALT   = 4'd5,
        S_ERROR  = 4'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [C_WAIT_W-1:0] r_wait;
    logic [1:0]          r_cause;
    logic [31:0]         r_instret;
    logic                w_cause_set;
    logic [1:0]          w_cause_val;
    logic                w_timeout;
    logic                w_wait_inc;

    // Instruction class decode; ss = 11 is not a legal load/store size.
    logic w_is_alu, w_is_upp, w_is_store, w_is_load, w_is_jump, w_is_ebreak;
    assign w_is_alu    = (inst_type == 4'b0001) || (inst_type == 4'b0010);
    assign w_is_upp    = (inst_type == 4'b0011);
    assign w_is_store  = (inst_type[3:2] == 2'b01) && (inst_type[1:0] != 2'b11);
    assign w_is_load   = (inst_type[3:2] == 2'b10) && (inst_type[1:0] != 2'b11);
    assign w_is_jump   = (inst_type == 4'b1100);
    assign w_is_ebreak = (inst_type == 4'b1101);

    assign w_timeout = (r_wait == C_WAIT_W'(MEM_TIMEOUT));

    always_comb begin
        w_next      = r_state;
        w_cause_set = 1'b0;
        w_cause_val = 2'b00;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_size    = 2'b00;
        addr_sel    = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 2'b00;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        halt        = 1'b0;
        error       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_size = 2'b10;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next      = S_ERROR;
                    w_cause_set = 1'b1;
                    w_cause_val = 2'b10;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_is_alu || w_is_upp || w_is_jump) begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_FETCH;
                    if (w_is_upp) begin
                        wb_sel = 2'd3;
                    end else if (w_is_jump) begin
                        wb_sel = 2'd2;
                        pc_sel = 1'b1;
                    end
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else if (w_is_ebreak) begin
                    w_next = S_HALT;
                end else begin
                    w_next      = S_ERROR;
                    w_cause_set = 1'b1;
                    w_cause_val = 2'b01;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_size = inst_type[1:0];
                mem_we   = (inst_type[3:2] == 2'b01);
                if (mem_ready) begin
                    pc_we  = 1'b1;
                    w_next = S_FETCH;
                    if (w_is_load) begin
                        reg_we = 1'b1;
                        wb_sel = 2'd1;
                    end
                end else if (w_timeout) begin
                    w_next      = S_ERROR;
                    w_cause_set = 1'b1;
                    w_cause_val = 2'b11;
                end
            end
            S_HALT: begin
                halt = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The counter only advances while a request keeps waiting in place. Any
    // state change clears it, so every entry to FETCH or MEM starts at zero.
    assign w_wait_inc = ((r_state == S_FETCH) || (r_state == S_MEM)) &&
                        !mem_ready && (w_next == r_state);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_cause   <= 2'b00;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_inc ? (r_wait + C_WAIT_W'(1)) : '0;
            if (w_cause_set) begin
                r_cause <= w_cause_val;
            end
            if (pc_we) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign err_cause = r_cause;
    assign state     = r_state;
    assign instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_fsm
// Description : Directed self-checking bench for ctrl_fsm. Each step queues
//               the cycle's expected outputs and compares them mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  inst_type = 4'b0000;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, pc_sel;
    logic        halt, error;
    logic [1:0]  mem_size, wb_sel, err_cause;
    logic [3:0]  state;
    logic [31:0] instret;

    always #5 clock = ~clock;

    ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .inst_type (inst_type),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .halt      (halt),
        .error     (error),
        .err_cause (err_cause),
        .state     (state),
        .instret   (instret)
    );

    logic [18:0] obs;
    assign obs = {state, mem_req, mem_we, mem_size, addr_sel, ir_we, reg_we,
                  wb_sel, pc_we, pc_sel, halt, error, err_cause};

    int          total = 0;
    int          bad   = 0;
    logic [18:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] exp_instret;

    function automatic logic [18:0] ev(input logic [3:0] st, input logic mreq,
            input logic mwe, input logic [1:0] msz, input logic asel,
            input logic irwe, input logic regwe, input logic [1:0] wb,
            input logic pcwe, input logic pcsel, input logic hlt,
            input logic err, input logic [1:0] cause);
        return {st, mreq, mwe, msz, asel, irwe, regwe, wb, pcwe, pcsel, hlt, err, cause};
    endfunction

    function automatic logic [18:0] f_idle();
        return ev(4'd0, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [18:0] f_fetch(input logic rdy);
        return ev(4'd1, 1, 0, 2'b10, 0, rdy, 0, 2'd0, 0, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [18:0] f_dec();
        return ev(4'd2, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [18:0] f_exec(input logic regwe, input logic [1:0] wb,
            input logic pcwe, input logic pcsel);
        return ev(4'd3, 0, 0, 2'b00, 0, 0, regwe, wb, pcwe, pcsel, 0, 0, 2'b00);
    endfunction
    function automatic logic [18:0] f_mem(input logic we, input logic [1:0] sz,
            input logic rdy, input logic load);
        return ev(4'd4, 1, we, sz, 1, 0, rdy & load, (rdy & load) ? 2'd1 : 2'd0,
                  rdy, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [18:0] f_halt();
        return ev(4'd5, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0, 0, 1, 0, 2'b00);
    endfunction
    function automatic logic [18:0] f_err(input logic [1:0] cause);
        return ev(4'd6, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0, 0, 0, 1, cause);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Called at posedge+1: drive inputs and queue the expectation, then
    // compare at the following negedge and return at the next posedge+1.
    task automatic step(input logic [3:0] it, input logic rdy,
                        input logic [18:0] e, input string tag);
        logic [18:0] ex;
        string       tg;
        inst_type = it;
        mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clock);
        ex = exp_q.pop_front();
        tg = tag_q.pop_front();
        chk(tg, {13'd0, obs}, {13'd0, ex});
        @(posedge clock);
        #1;
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_outs"}, {13'd0, obs}, {13'd0, f_idle()});
        chk({tag, "_instret"}, instret, 32'd0);
        exp_instret = 32'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(4'b0000, 1'b1, f_idle(), {tag, "_idle"});
    endtask

    // Fetch/decode/execute of a non-memory, retiring instruction.
    task automatic run_alu(input logic [3:0] it, input logic [1:0] wb,
                           input logic pcsel, input string tag);
        step(it, 1'b1, f_fetch(1'b1), {tag, "_fetch"});
        step(4'b0000, 1'b1, f_dec(), {tag, "_dec"});
        step(it, 1'b0, f_exec(1'b1, wb, 1'b1, pcsel), {tag, "_exec"});
        exp_instret = exp_instret + 32'd1;
        chk({tag, "_instret"}, instret, exp_instret);
    endtask

    initial begin
        exp_instret = 32'd0;
        #2;
        chk("reset_outs", {13'd0, obs}, {13'd0, f_idle()});
        chk("reset_instret", instret, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(4'b0001, 1'b1, f_idle(), "idle_after_reset");

        // IMM, REG, UPP, JUMP with zero-wait memory
        run_alu(4'b0001, 2'd0, 1'b0, "imm");
        run_alu(4'b0010, 2'd0, 1'b0, "reg");
        run_alu(4'b0011, 2'd3, 1'b0, "upp");
        run_alu(4'b1100, 2'd2, 1'b1, "jump");

        // LOAD word, ready delayed three cycles in MEM
        step(4'b1010, 1'b1, f_fetch(1'b1), "lw_fetch");
        step(4'b1010, 1'b0, f_dec(), "lw_dec");
        step(4'b1010, 1'b0, f_exec(1'b0, 2'd0, 1'b0, 1'b0), "lw_exec");
        for (int i = 0; i < 3; i++)
            step(4'b1010, 1'b0, f_mem(1'b0, 2'b10, 1'b0, 1'b1), "lw_mem_wait");
        step(4'b1010, 1'b1, f_mem(1'b0, 2'b10, 1'b1, 1'b1), "lw_mem_ready");
        exp_instret = exp_instret + 32'd1;
        chk("lw_instret", instret, exp_instret);

        // STORE byte, zero wait
        step(4'b0100, 1'b1, f_fetch(1'b1), "sb_fetch");
        step(4'b0100, 1'b0, f_dec(), "sb_dec");
        step(4'b0100, 1'b0, f_exec(1'b0, 2'd0, 1'b0, 1'b0), "sb_exec");
        step(4'b0100, 1'b1, f_mem(1'b1, 2'b00, 1'b1, 1'b0), "sb_mem_ready");
        exp_instret = exp_instret + 32'd1;
        chk("sb_instret", instret, exp_instret);

        // Fetch ready arrives exactly when the wait count reaches 16
        for (int i = 0; i < 16; i++)
            step(4'b0001, 1'b0, f_fetch(1'b0), "fetch_wait");
        step(4'b0001, 1'b1, f_fetch(1'b1), "fetch_ready_at_16");
        step(4'b0001, 1'b0, f_dec(), "late_dec");
        step(4'b0001, 1'b0, f_exec(1'b1, 2'd0, 1'b1, 1'b0), "late_exec");
        exp_instret = exp_instret + 32'd1;
        chk("late_instret", instret, exp_instret);

        // instret wrap: preset during DECODE, then retire two instructions
        step(4'b0001, 1'b1, f_fetch(1'b1), "wrap_fetch");
        force dut.r_instret = 32'hFFFF_FFFE;
        #1;
        release dut.r_instret;
        exp_instret = 32'hFFFF_FFFE;
        step(4'b0001, 1'b0, f_dec(), "wrap_dec");
        step(4'b0001, 1'b0, f_exec(1'b1, 2'd0, 1'b1, 1'b0), "wrap_exec");
        chk("instret_ffffffff", instret, 32'hFFFF_FFFF);
        exp_instret = 32'hFFFF_FFFF;
        run_alu(4'b1100, 2'd2, 1'b1, "wrap_jump");
        chk("instret_wrapped", instret, 32'h0000_0000);

        // EBREAK halts and holds; instret unchanged
        step(4'b1101, 1'b1, f_fetch(1'b1), "ebrk_fetch");
        step(4'b1101, 1'b0, f_dec(), "ebrk_dec");
        step(4'b1101, 1'b0, f_exec(1'b0, 2'd0, 1'b0, 1'b0), "ebrk_exec");
        step(4'b0001, 1'b1, f_halt(), "halt");
        step(4'b0001, 1'b1, f_halt(), "halt_sticky");
        chk("halt_instret", instret, exp_instret);
        async_reset("rst_halt");

        // Invalid classes raise err_cause 01
        step(4'b0111, 1'b1, f_fetch(1'b1), "inv_fetch");
        step(4'b0111, 1'b0, f_dec(), "inv_dec");
        step(4'b0111, 1'b0, f_exec(1'b0, 2'd0, 1'b0, 1'b0), "inv_exec");
        step(4'b0001, 1'b1, f_err(2'b01), "inv_error");
        step(4'b0001, 1'b1, f_err(2'b01), "inv_error_sticky");
        chk("inv_instret", instret, 32'd0);
        async_reset("rst_inv");
        step(4'b1011, 1'b1, f_fetch(1'b1), "ss11_fetch");
        step(4'b1011, 1'b0, f_dec(), "ss11_dec");
        step(4'b1011, 1'b0, f_exec(1'b0, 2'd0, 1'b0, 1'b0), "ss11_exec");
        step(4'b1011, 1'b0, f_err(2'b01), "ss11_error");
        async_reset("rst_ss11");

        // Fetch timeout: 16 wait cycles, then count 16 with no ready
        for (int i = 0; i < 16; i++)
            step(4'b0001, 1'b0, f_fetch(1'b0), "fto_wait");
        step(4'b0001, 1'b0, f_fetch(1'b0), "fto_count16");
        step(4'b0001, 1'b1, f_err(2'b10), "fto_error");
        step(4'b0001, 1'b1, f_err(2'b10), "fto_error_sticky");
        async_reset("rst_fto");

        // MEM timeout on a half-word load
        step(4'b1001, 1'b1, f_fetch(1'b1), "mto_fetch");
        step(4'b1001, 1'b0, f_dec(), "mto_dec");
        step(4'b1001, 1'b0, f_exec(1'b0, 2'd0, 1'b0, 1'b0), "mto_exec");
        for (int i = 0; i < 17; i++)
            step(4'b1001, 1'b0, f_mem(1'b0, 2'b01, 1'b0, 1'b1), "mto_wait");
        step(4'b1001, 1'b1, f_err(2'b11), "mto_error");
        async_reset("rst_mto");

        // Reset asserted in the second MEM wait cycle
        step(4'b1001, 1'b1, f_fetch(1'b1), "rmid_fetch");
        step(4'b1001, 1'b0, f_dec(), "rmid_dec");
        step(4'b1001, 1'b0, f_exec(1'b0, 2'd0, 1'b0, 1'b0), "rmid_exec");
        step(4'b1001, 1'b0, f_mem(1'b0, 2'b01, 1'b0, 1'b1), "rmid_wait1");
        #2;
        chk("rmid_wait2", {13'd0, obs}, {13'd0, f_mem(1'b0, 2'b01, 1'b0, 1'b1)});
        reset = 1'b1;
        #1;
        chk("rmid_mem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rmid_outs", {13'd0, obs}, {13'd0, f_idle()});
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(4'b1001, 1'b0, f_idle(), "rmid_idle");
        step(4'b1001, 1'b0, f_fetch(1'b0), "rmid_refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
